muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, beside the 32-bit ALU.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake/result bundle between the EX-stage control and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, wr_hi, wr_lo, wr_data,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, A, B, wr_hi, wr_lo, wr_data,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitudes are processed one bit per
// clock, then a single fix-up cycle applies signs and writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    step_reg;
    logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg;
    logic             is_div_reg, res_neg_reg, rem_neg_reg, dz_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             done_reg, dbz_reg;
    logic             busy;

    // Operand conditioning at launch
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign a_neg = ~bus.op[0] & bus.A[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.B[WIDTH-1];
    assign mag_a = a_neg ? (~bus.A + 1'b1) : bus.A;
    assign mag_b = b_neg ? (~bus.B + 1'b1) : bus.B;

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    // acc_hi/acc_lo hold the running product, or remainder/dividend-quotient.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] diff, rem_next;

    assign mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    assign trial    = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign fits     = (trial >= {1'b0, opnd_reg});
    assign diff     = trial[WIDTH-1:0] - opnd_reg;
    assign rem_next = fits ? diff : trial[WIDTH-1:0];

    // Sign correction applied in the FIX cycle
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

    assign prod     = {acc_hi_reg, acc_lo_reg};
    assign prod_fix = res_neg_reg ? (~prod + 1'b1) : prod;
    assign q_fix    = dz_reg ? {WIDTH{1'b1}}
                    : (res_neg_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg);
    assign r_fix    = rem_neg_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
    assign fix_hi   = is_div_reg ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div_reg ? q_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (step_reg == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_reg    <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            res_neg_reg <= 1'b0;
            rem_neg_reg <= 1'b0;
            dz_reg      <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIX);
            dbz_reg  <= (state_reg == FIX) && dz_reg;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        is_div_reg  <= bus.op[1];
                        res_neg_reg <= a_neg ^ b_neg;
                        rem_neg_reg <= bus.op[1] & a_neg;
                        dz_reg      <= bus.op[1] & (bus.B == '0);
                        opnd_reg    <= bus.op[1] ? mag_b : mag_a;
                        acc_lo_reg  <= bus.op[1] ? mag_a : mag_b;
                        acc_hi_reg  <= '0;
                        step_reg    <= '0;
                    end else begin
                        // MTHI/MTLO only land when no op is being launched
                        if (bus.wr_hi) hi_reg <= bus.wr_data;
                        if (bus.wr_lo) lo_reg <= bus.wr_data;
                    end
                end
                CALC: begin
                    step_reg <= step_reg + CW'(1);
                    if (is_div_reg) begin
                        acc_hi_reg <= rem_next;
                        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], fits};
                    end else begin
                        {acc_hi_reg, acc_lo_reg} <= {mul_sum, acc_lo_reg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_reg <= fix_hi;
                    lo_reg <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_reg;
    assign bus.dbz  = dbz_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [WIDTH-1:0] exp_hi = '0;
    logic [WIDTH-1:0] exp_lo = '0;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns {dbz, hi, lo} from plain integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, p, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = sa * sb; return {1'b0, p[63:0]}; end
            2'd1: begin u = {32'b0, a} * {32'b0, b}; return {1'b0, u}; end
            2'd2: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit wr_too);
        logic [64:0] m;
        int          k;
        bit          ok_busy, ok_hold;
        ok_busy = 1;
        ok_hold = 1;
        m = model(op, a, b);
        bus.start = 1'b1;
        bus.op = op;
        bus.A = a;
        bus.B = b;
        if (wr_too) begin
            bus.wr_hi = 1'b1;
            bus.wr_lo = 1'b1;
            bus.wr_data = 32'h0BAD_F00D;
        end
        step();
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        k = 1;
        while (bus.done !== 1'b1 && k < 100) begin
            if (bus.busy !== 1'b1) ok_busy = 0;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo) ok_hold = 0;
            step();
            k++;
        end
        check_eq("latency", 64'(k), 64'(WIDTH + 2));
        check_eq("busy_during_op", 64'(ok_busy), 64'd1);
        check_eq("hilo_hold", 64'(ok_hold), 64'd1);
        check_eq("busy_at_done", 64'(bus.busy), 64'd0);
        check_eq("hi", 64'(bus.hi), 64'(m[63:32]));
        check_eq("lo", 64'(bus.lo), 64'(m[31:0]));
        check_eq("dbz", 64'(bus.dbz), 64'(m[64]));
        exp_hi = m[63:32];
        exp_lo = m[31:0];
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b", op, a, b, bus.hi, bus.lo, bus.dbz);
        step();
        check_eq("done_pulse", 64'(bus.done), 64'd0);
        check_eq("dbz_pulse", 64'(bus.dbz), 64'd0);
    endtask

    initial begin
        int          k, k1, k2, ndone;
        bit          ok;
        logic [1:0]  op;
        logic [31:0] a, b;

        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.A = '0;
        bus.B = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wr_data = '0;

        repeat (3) step();
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_dbz", 64'(bus.dbz), 64'd0);
        check_eq("rst_hi", 64'(bus.hi), 64'd0);
        check_eq("rst_lo", 64'(bus.lo), 64'd0);
        reset_n = 1'b1;
        step();

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd3, 32'd100, 32'd0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0);

        // MTHI / MTLO in IDLE
        bus.wr_hi = 1'b1;
        bus.wr_data = 32'h1234_5678;
        step();
        bus.wr_hi = 1'b0;
        check_eq("mthi", 64'(bus.hi), 64'h1234_5678);
        check_eq("mthi_lo_kept", 64'(bus.lo), 64'(exp_lo));
        exp_hi = 32'h1234_5678;
        bus.wr_lo = 1'b1;
        bus.wr_data = 32'h9ABC_DEF0;
        step();
        bus.wr_lo = 1'b0;
        check_eq("mtlo", 64'(bus.lo), 64'h9ABC_DEF0);
        exp_lo = 32'h9ABC_DEF0;

        // start and write in the same cycle: the write must be dropped
        run_op(2'd3, 32'd1000, 32'd7, 1);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(op, a, b, 0);
        end

        // Held start: relaunch in the done cycle, write during busy dropped
        bus.start = 1'b1;
        bus.op = 2'd0;
        bus.A = 32'd2;
        bus.B = 32'd3;
        k1 = -1;
        k2 = -1;
        ndone = 0;
        for (k = 1; k <= 80; k++) begin
            if (k == 5) begin
                bus.wr_lo = 1'b1;
                bus.wr_data = 32'h55;
            end else begin
                bus.wr_lo = 1'b0;
            end
            if (k == 41) bus.start = 1'b0;
            step();
            if (k == 6) check_eq("mtlo_busy_dropped", 64'(bus.lo), 64'(exp_lo));
            if (bus.done === 1'b1) begin
                ndone++;
                if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
                check_eq("held_lo", 64'(bus.lo), 64'd6);
                check_eq("held_hi", 64'(bus.hi), 64'd0);
            end
            if (k1 > 0 && k == k1 + 1) check_eq("relaunch_busy", 64'(bus.busy), 64'd1);
        end
        bus.start = 1'b0;
        check_eq("held_done_count", 64'(ndone), 64'd2);
        check_eq("held_first_done", 64'(k1), 64'(WIDTH + 2));
        check_eq("held_second_done", 64'(k2), 64'(2 * (WIDTH + 2)));
        check_eq("held_idle_after", 64'(bus.busy), 64'd0);
        $display("held start: done at %0d and %0d", k1, k2);
        exp_hi = 32'd0;
        exp_lo = 32'd6;

        run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_1001, 0);

        // Reset during CALC step 10 of a divide
        bus.start = 1'b1;
        bus.op = 2'd2;
        bus.A = 32'hFFFF_0000;
        bus.B = 32'd3;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_hi", 64'(bus.hi), 64'd0);
        check_eq("midrst_lo", 64'(bus.lo), 64'd0);
        #2;
        reset_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        ok = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 0;
        end
        check_eq("midrst_no_done", 64'(ok), 64'd1);
        $display("reset mid-divide: abandoned");
        run_op(2'd1, 32'd12345, 32'd6789, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
